// File: rtl/softex_cast_out_ctrl_if.sv
// Stream-side signals of the SoftEx output cast controller, plus the shared
// cast configuration package.
//
// softex_cast_out_ctrl_if
//   upstream_valid  producer valid
//   upstream_ready  producer ready (gated by the controller)
//   cast_valid      valid into the cast stage (gated by the controller)
//   cast_ready      ready from the cast stage
//   strb_mask       AND-mask for the input strobe of the current beat
//   last            current beat is the last of the job
// modport master: the controller; modport slave: producer/cast-stage side.

interface softex_cast_out_ctrl_if #(
   parameter int unsigned STRB_W = 32
);
   logic              upstream_valid;
   logic              upstream_ready;
   logic              cast_valid;
   logic              cast_ready;
   logic [STRB_W-1:0] strb_mask;
   logic              last;

   modport master (
      input  upstream_valid, cast_ready,
      output upstream_ready, cast_valid, strb_mask, last
   );

   modport slave (
      output upstream_valid, cast_ready,
      input  upstream_ready, cast_valid, strb_mask, last
   );
endinterface

package softex_cast_pkg;
   localparam int unsigned DATA_W = 288;

   typedef enum logic [1:0] {FP8, FP16, BF16, FP32} fp_format_e;

   localparam fp_format_e FPFORMAT_IN = FP16;

   typedef struct packed {
      logic       enable;
      logic       is_signed;
      logic [5:0] int_bits;
   } cast_ctrl_t;

   function automatic int unsigned fp_width(input fp_format_e fmt);
      case (fmt)
         FP8:        return 8;
         FP16, BF16: return 16;
         default:    return 32;
      endcase
   endfunction
endpackage

// File: rtl/softex_cast_out_ctrl.sv
// Job-level sequencer for the SoftEx output cast stage. Latches the cast
// configuration and element count on start, gates the upstream stream into
// the cast stage while a job runs, counts accepted beats, masks the unused
// lanes of the final partial beat and pulses done_o at job completion.
//
// Ports
//   clk_i, rst_i  clock, synchronous active-high reset
//   start_i       job start (sampled only when idle)
//   cfg_i         cast configuration for the next job
//   tot_len_i     number of FP elements in the job
//   ctrl_o        configuration held for the cast stage
//   stream        gated handshake, strobe mask and last flag (master side)
//   busy_o        job in progress (not idle)
//   done_o        single-cycle completion pulse

module softex_cast_out_ctrl
   import softex_cast_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_W,
   parameter fp_format_e  FPFORMAT   = FPFORMAT_IN,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  cast_ctrl_t             cfg_i,
   input  logic [CNT_WIDTH-1:0]   tot_len_i,
   output cast_ctrl_t             ctrl_o,
   softex_cast_out_ctrl_if.master stream,
   output logic                   busy_o,
   output logic                   done_o
);
   localparam int unsigned FP_WIDTH      = fp_width(FPFORMAT);
   localparam int unsigned NUM_ROWS      = (DATA_WIDTH - 32) / FP_WIDTH;
   localparam int unsigned STRB_W        = (DATA_WIDTH - 32) / 8;
   localparam int unsigned BYTES_PER_ROW = FP_WIDTH / 8;
   localparam int unsigned ROW_SHIFT     = $clog2(NUM_ROWS);
   localparam logic [CNT_WIDTH-1:0] ROW_MASK = CNT_WIDTH'(NUM_ROWS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   cast_ctrl_t           ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0] n_beats_q, n_beats_d;
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [STRB_W-1:0]    tail_mask_q, tail_mask_d;

   logic [CNT_WIDTH-1:0] len_rem;
   logic [CNT_WIDTH-1:0] start_beats;
   logic [STRB_W-1:0]    start_mask;
   int unsigned          tail_bytes;
   logic                 run;
   logic                 is_last;
   logic                 handshake;

   // Beat count and final-beat mask of the job offered on tot_len_i.
   // Shift-then-round-up keeps the count inside CNT_WIDTH even for the
   // largest tot_len_i, which a (len + NUM_ROWS - 1) form would not.
   always_comb begin
      len_rem     = tot_len_i & ROW_MASK;
      start_beats = (tot_len_i >> ROW_SHIFT) + CNT_WIDTH'(len_rem != '0);
      // A zero remainder means the final beat is full.
      tail_bytes  = (len_rem == '0) ? STRB_W : 32'(len_rem) * BYTES_PER_ROW;
      start_mask  = '0;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         start_mask[b] = (b < tail_bytes);
      end
   end

   assign run       = (state_q == StRun);
   assign is_last   = run && (beat_cnt_q == (n_beats_q - 1'b1));
   assign handshake = run && stream.upstream_valid && stream.cast_ready;

   always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      n_beats_d   = n_beats_q;
      beat_cnt_d  = beat_cnt_q;
      tail_mask_d = tail_mask_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               ctrl_d      = cfg_i;
               n_beats_d   = start_beats;
               tail_mask_d = start_mask;
               beat_cnt_d  = '0;
               state_d     = (start_beats != '0) ? StRun : StDone;
            end
         end
         StRun: begin
            if (handshake) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (is_last) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         ctrl_q      <= '0;
         n_beats_q   <= '0;
         beat_cnt_q  <= '0;
         tail_mask_q <= '0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         n_beats_q   <= n_beats_d;
         beat_cnt_q  <= beat_cnt_d;
         tail_mask_q <= tail_mask_d;
      end
   end

   // Stream gating is purely combinational: no added latency on the data path.
   assign stream.cast_valid     = stream.upstream_valid & run;
   assign stream.upstream_ready = stream.cast_ready & run;
   assign stream.last           = is_last;
   assign stream.strb_mask      = !run ? '0 : (is_last ? tail_mask_q : '1);

   assign ctrl_o = ctrl_q;
   assign busy_o = (state_q != StIdle);
   assign done_o = (state_q == StDone);

endmodule

// File: tb/tb_softex_cast_out_ctrl.sv
// Self-checking bench for softex_cast_out_ctrl (288-bit stream, FP16:
// 16 rows per beat, 32 strobe bits). A job-level reference model predicts
// every output each cycle; directed jobs cover the listed scenarios and a
// randomized phase adds stalls, mid-job starts and resets.

module tb_softex_cast_out_ctrl;
   import softex_cast_pkg::*;

   localparam int unsigned STRB_W = 32;
   localparam longint      ROWS   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   cast_ctrl_t  cfg;
   logic [31:0] tot_len;
   cast_ctrl_t  ctrl;
   logic        busy;
   logic        done;

   softex_cast_out_ctrl_if #(.STRB_W(STRB_W)) stream ();

   softex_cast_out_ctrl #(
      .DATA_WIDTH (288),
      .FPFORMAT   (FP16),
      .CNT_WIDTH  (32)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .cfg_i     (cfg),
      .tot_len_i (tot_len),
      .ctrl_o    (ctrl),
      .stream    (stream),
      .busy_o    (busy),
      .done_o    (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: job phase (0 idle, 1 streaming, 2 completion cycle)
   int         m_phase  = 0;
   cast_ctrl_t m_ctrl   = '0;
   longint     m_nbeats = 0;
   longint     m_beats  = 0;
   longint     m_tail   = 0;

   // Per-job observations of the DUT
   int          hs_cnt;
   int          done_cnt;
   logic [31:0] last_mask_seen;

   localparam cast_ctrl_t CFG_A = '{enable: 1'b1, is_signed: 1'b0, int_bits: 6'd8};
   localparam cast_ctrl_t CFG_B = '{enable: 1'b0, is_signed: 1'b1, int_bits: 6'd3};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Low 2*tail strobe bits (two bytes per FP16 row).
   function automatic logic [31:0] model_mask(input longint tail);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < tail * 2; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic cast_ctrl_t rand_cfg();
      return cast_ctrl_t'(8'($urandom));
   endfunction

   // One clock: drive at negedge, check outputs, then advance the model.
   task automatic cycle(input bit r, input bit s, input cast_ctrl_t c, input logic [31:0] len,
                        input bit v, input bit rdy);
      bit          run;
      bit          lst;
      logic [31:0] emask;
      @(negedge clk);
      rst   = r;
      start = s;
      cfg   = c;
      tot_len = len;
      stream.upstream_valid = v;
      stream.cast_ready     = rdy;
      #1;
      run   = (m_phase == 1);
      lst   = run && (m_beats == m_nbeats - 1);
      emask = !run ? 32'h0 : (lst ? model_mask(m_tail) : 32'hFFFF_FFFF);
      check_eq("cast_valid", 64'(stream.cast_valid), 64'(v & run));
      check_eq("upstream_ready", 64'(stream.upstream_ready), 64'(rdy & run));
      check_eq("last", 64'(stream.last), 64'(lst));
      check_eq("strb_mask", 64'(stream.strb_mask), 64'(emask));
      check_eq("busy", 64'(busy), 64'(m_phase != 0));
      check_eq("done", 64'(done), 64'(m_phase == 2));
      check_eq("ctrl", 64'(ctrl), 64'(m_ctrl));
      if (stream.cast_valid && rdy) begin
         hs_cnt++;
         if (stream.last) last_mask_seen = stream.strb_mask;
      end
      if (done) done_cnt++;
      if (r) begin
         m_phase = 0;
         m_ctrl  = '0;
         m_beats = 0;
      end else begin
         case (m_phase)
            0: if (s) begin
               m_ctrl   = c;
               m_nbeats = (longint'(len) + ROWS - 1) / ROWS;
               m_tail   = longint'(len) - (m_nbeats - 1) * ROWS;
               m_beats  = 0;
               m_phase  = (m_nbeats > 0) ? 1 : 2;
            end
            1: if (v && rdy) begin
               m_beats++;
               if (m_beats == m_nbeats) m_phase = 2;
            end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic start_job(input cast_ctrl_t c, input logic [31:0] len);
      hs_cnt = 0;
      done_cnt = 0;
      last_mask_seen = '0;
      cycle(1'b0, 1'b1, c, len, 1'b1, 1'b1);
   endtask

   // Runs until the model is idle; rnd adds stalls, stray starts and rare resets.
   // Mid-job cfg/len are randomized: the DUT must ignore them.
   task automatic finish_job(input int budget, input bit rnd);
      int n;
      bit v, rdy, r, s;
      n = 0;
      while (m_phase != 0 && n < budget) begin
         v   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         r   = rnd && ($urandom_range(0, 99) == 0);
         s   = rnd && ($urandom_range(0, 7) == 0);
         cycle(r, s, rand_cfg(), $urandom(), v, rdy);
         n++;
      end
      check_eq("job_finished", 64'(m_phase), 64'(0));
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      cfg = '0;
      tot_len = '0;
      stream.upstream_valid = 1'b0;
      stream.cast_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state, then idle with stream activity that must stay gated
      cycle(1'b1, 1'b0, CFG_A, 32'd5, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, CFG_A, 32'd5, 1'b1, 1'b1);

      // Full beats
      start_job(CFG_A, 32'd48);
      finish_job(20, 1'b0);
      check_eq("full_hs", 64'(hs_cnt), 64'(3));
      check_eq("full_last_mask", 64'(last_mask_seen), 64'hFFFF_FFFF);
      check_eq("full_done_pulses", 64'(done_cnt), 64'(1));

      // Tail beat, started back-to-back in the first idle cycle
      start_job(CFG_B, 32'd20);
      finish_job(20, 1'b0);
      check_eq("tail_hs", 64'(hs_cnt), 64'(2));
      check_eq("tail_last_mask", 64'(last_mask_seen), 64'h0000_00FF);

      // Empty job
      start_job(CFG_A, 32'd0);
      finish_job(5, 1'b0);
      check_eq("empty_hs", 64'(hs_cnt), 64'(0));
      check_eq("empty_done_pulses", 64'(done_cnt), 64'(1));

      // Backpressure during beat 1
      start_job(CFG_A, 32'd32);
      repeat (5) cycle(1'b0, 1'b0, CFG_B, 32'd7, 1'b1, 1'b0);
      finish_job(20, 1'b0);
      check_eq("bp_hs", 64'(hs_cnt), 64'(2));

      // Config isolation: second start mid-run is ignored
      start_job(CFG_A, 32'd48);
      cycle(1'b0, 1'b0, CFG_B, 32'd5, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, CFG_B, 32'd5, 1'b1, 1'b1);
      finish_job(20, 1'b0);
      check_eq("iso_hs", 64'(hs_cnt), 64'(3));
      check_eq("iso_ctrl", 64'(ctrl), 64'(CFG_A));

      // Reset during beat 2 of 3, then a fresh job
      start_job(CFG_A, 32'd48);
      cycle(1'b0, 1'b0, CFG_A, 32'd0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, CFG_A, 32'd0, 1'b1, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, CFG_A, 32'd0, 1'b1, 1'b1);
      check_eq("rst_no_done", 64'(done_cnt), 64'(0));
      check_eq("rst_ctrl", 64'(ctrl), 64'(0));
      start_job(CFG_B, 32'd17);
      finish_job(20, 1'b0);
      check_eq("post_rst_hs", 64'(hs_cnt), 64'(2));
      check_eq("post_rst_last_mask", 64'(last_mask_seen), 64'h0000_0003);

      // Largest length: beat count must not wrap to a short job
      start_job(CFG_A, 32'hFFFF_FFFF);
      repeat (3) cycle(1'b0, 1'b0, CFG_A, 32'd0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, CFG_A, 32'd0, 1'b0, 1'b0);

      // Randomized jobs
      for (int j = 0; j < 40; j++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            cycle(1'b0, 1'b0, rand_cfg(), $urandom(), 1'($urandom), 1'($urandom));
         end
         start_job(rand_cfg(), 32'($urandom_range(0, 100)));
         finish_job(400, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
